// File: rtl/kv_pkt_pkg.sv
// -----------------------------------------------------------------------------
// kv_pkt_pkg
// Shared constants and types for the KV reply packet generator.
//   - Ethernet / IPv4 / UDP header constants for the fixed 60-byte reply frame
//   - Frame geometry on the 64-bit AXI-Stream (beat count, last-beat tkeep)
//   - FSM state type used by kv_pkt_gen
// -----------------------------------------------------------------------------
package kv_pkt_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] IP_TOTAL_LEN   = 16'd45;   // 20 IP + 8 UDP + 17 payload
    localparam logic [15:0] UDP_LEN        = 16'd25;   // 8 UDP + 17 payload
    localparam int          FRAME_BEATS    = 8;
    localparam logic [7:0]  LAST_TKEEP     = 8'h0F;    // bytes 56..59 only
    localparam logic [2:0]  LAST_BEAT      = 3'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CSUM = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/ip_csum16.sv
// -----------------------------------------------------------------------------
// ip_csum16
// Combinational 16-bit ones-complement sum of ten 16-bit words (an IPv4
// header with the checksum field zeroed). The caller inverts the result to
// obtain the header checksum.
// Ports:
//   i_words  in  10x16  header words (order does not matter)
//   o_sum    out 16     ones-complement sum, end-around carry folded twice
// -----------------------------------------------------------------------------
module ip_csum16 (
    input  logic [9:0][15:0] i_words,
    output logic [15:0]      o_sum
);

    logic [19:0] w_acc;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // Ten 16-bit words fit in 20 bits without overflow.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < 10; i++) begin
            w_acc = w_acc + {4'h0, i_words[i]};
        end
    end

    // First fold can still produce a carry; after the second fold it cannot
    // (max 0xFFFF + 0xF = 0x1000E -> 0x000E + 1).
    assign w_fold1 = {1'b0, w_acc[15:0]} + {13'h0, w_acc[19:16]};
    assign w_fold2 = w_fold1[15:0] + {15'h0, w_fold1[16]};
    assign o_sum   = w_fold2;

endmodule

// File: rtl/kv_pkt_gen.sv
// -----------------------------------------------------------------------------
// kv_pkt_gen
// Builds a fixed 60-byte Ethernet/IPv4/UDP reply frame for each KV lookup
// result and streams it to a 10G MAC as 8 beats of 64-bit AXI-Stream.
// Flow: IDLE (accept request) -> CSUM (one cycle, register IPv4 checksum)
//       -> SEND (8 beats, advance on handshake) -> IDLE, ip_id increments.
//
// Ports:
//   clk156, eth_rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake from the lookup side
//   req_key[95:0], req_flag[3:0], req_val[31:0]   reply payload
//   m_axis_t*                   MAC TX stream (tuser always 0)
//   tx_frames, tx_stalls        statistics counters
//
// Build option: define KV_PKT_GEN_STATS_EN to enable the saturating
// tx_frames / tx_stalls counters; otherwise both outputs are tied to 0.
// -----------------------------------------------------------------------------
module kv_pkt_gen
    import kv_pkt_pkg::*;
#(
    parameter logic [47:0] SRC_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
    parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
    parameter logic [15:0] UDP_PORT = 16'd8000
) (
    input  logic        clk156,
    input  logic        eth_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [95:0] req_key,
    input  logic [3:0]  req_flag,
    input  logic [31:0] req_val,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [31:0] tx_frames,
    output logic [31:0] tx_stalls
);

    state_t      r_state;
    state_t      w_state_next;
    logic [95:0] r_key;
    logic [3:0]  r_flag;
    logic [31:0] r_val;
    logic [15:0] r_ip_id;
    logic [15:0] r_csum;
    logic [2:0]  r_beat;
    logic        r_rst_done;

    logic             w_accept;
    logic             w_beat_hs;
    logic             w_last_hs;
    logic [9:0][15:0] w_csum_words;
    logic [15:0]      w_csum_sum;
    logic [511:0]     w_frame;
    logic [8:0]       w_base;
    logic [63:0]      w_beat_word;
    logic [63:0]      w_beat_data;

    assign w_accept  = req_valid && req_ready;
    assign w_beat_hs = m_axis_tvalid && m_axis_tready;
    assign w_last_hs = w_beat_hs && (r_beat == LAST_BEAT);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = CSUM;
            CSUM:    w_state_next = SEND;
            SEND:    if (w_last_hs) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_key      <= '0;
            r_flag     <= '0;
            r_val      <= '0;
            r_ip_id    <= '0;
            r_csum     <= '0;
            r_beat     <= '0;
            r_rst_done <= 1'b0;
        end else begin
            // Holds req_ready low for the first cycle out of reset so it is
            // never seen high while the reset is still being applied.
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_key  <= req_key;
                r_flag <= req_flag;
                r_val  <= req_val;
            end
            if (r_state == CSUM) begin
                r_csum <= ~w_csum_sum;
                r_beat <= '0;
            end
            if (w_beat_hs) begin
                r_beat <= r_beat + 3'd1;
                if (r_beat == LAST_BEAT) begin
                    r_ip_id <= r_ip_id + 16'd1;
                end
            end
        end
    end

    // -------------------------------------------------- IPv4 header checksum
    assign w_csum_words = {
        {8'h45, 8'h00}, IP_TOTAL_LEN, r_ip_id, 16'h4000,
        {8'h40, IP_PROTO_UDP}, 16'h0000,
        SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0]
    };

    ip_csum16 u_csum (
        .i_words (w_csum_words),
        .o_sum   (w_csum_sum)
    );

    // --------------------------------------------------------- frame image
    // Frame byte 0 sits in the top byte of w_frame; four zero bytes pad the
    // 60-byte frame to a whole number of 8-byte beats.
    assign w_frame = {
        DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
        8'h45, 8'h00, IP_TOTAL_LEN, r_ip_id, 16'h4000,
        8'h40, IP_PROTO_UDP, r_csum, SRC_IP, DST_IP,
        UDP_PORT, UDP_PORT, UDP_LEN, 16'h0000,
        {4'h0, r_flag}, r_key, r_val, 8'h00,
        32'h0000_0000
    };

    assign w_base      = 9'd511 - {r_beat, 6'd0};
    assign w_beat_word = w_frame[w_base -: 64];

    // First frame byte of the beat goes to AXIS lane 0 (tdata[7:0]).
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign w_beat_data[8*gi +: 8] = w_beat_word[63-8*gi -: 8];
        end
    endgenerate

    // ------------------------------------------------------------- outputs
    // Outputs depend only on registered state, so they stay stable while a
    // beat is stalled on tready.
    assign req_ready     = (r_state == IDLE) && r_rst_done;
    assign m_axis_tvalid = (r_state == SEND);
    assign m_axis_tdata  = (r_state == SEND) ? w_beat_data : 64'h0;
    assign m_axis_tkeep  = (r_state != SEND)     ? 8'h00 :
                           (r_beat == LAST_BEAT) ? LAST_TKEEP : 8'hFF;
    assign m_axis_tlast  = (r_state == SEND) && (r_beat == LAST_BEAT);
    assign m_axis_tuser  = 1'b0;

    // ---------------------------------------------------------- statistics
`ifdef KV_PKT_GEN_STATS_EN
    logic [31:0] r_tx_frames;
    logic [31:0] r_tx_stalls;

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_tx_frames <= '0;
            r_tx_stalls <= '0;
        end else begin
            if (w_last_hs && (r_tx_frames != 32'hFFFF_FFFF)) begin
                r_tx_frames <= r_tx_frames + 32'd1;
            end
            if (m_axis_tvalid && !m_axis_tready && (r_tx_stalls != 32'hFFFF_FFFF)) begin
                r_tx_stalls <= r_tx_stalls + 32'd1;
            end
        end
    end

    assign tx_frames = r_tx_frames;
    assign tx_stalls = r_tx_stalls;
`else
    assign tx_frames = 32'h0;
    assign tx_stalls = 32'h0;
`endif

endmodule

// File: tb/tb_kv_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_kv_pkt_gen
// Self-checking bench for kv_pkt_gen. Expected beats are built byte by byte
// from the request fields and pushed to a queue when a request is accepted;
// a monitor pops and compares them on every tvalid&&tready. Outputs are
// sampled on the falling edge; inputs change just after the rising edge.
// -----------------------------------------------------------------------------
module tb_kv_pkt_gen;

    localparam logic [47:0] P_SRC_MAC  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] P_DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] P_SRC_IP   = 32'hC0A8_0001;
    localparam logic [31:0] P_DST_IP   = 32'hC0A8_0002;
    localparam logic [15:0] P_UDP_PORT = 16'd8000;

    logic        clk156 = 1'b0;
    logic        eth_rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [95:0] req_key = '0;
    logic [3:0]  req_flag = '0;
    logic [31:0] req_val = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [31:0] tx_frames;
    logic [31:0] tx_stalls;

    kv_pkt_gen #(
        .SRC_MAC  (P_SRC_MAC),
        .DST_MAC  (P_DST_MAC),
        .SRC_IP   (P_SRC_IP),
        .DST_IP   (P_DST_IP),
        .UDP_PORT (P_UDP_PORT)
    ) dut (
        .clk156        (clk156),
        .eth_rst_n     (eth_rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_flag      (req_flag),
        .req_val       (req_val),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .tx_frames     (tx_frames),
        .tx_stalls     (tx_stalls)
    );

    initial forever #5 clk156 = ~clk156;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [95:0] key;
        logic [3:0]  flag;
        logic [31:0] val;
        int          rdy_mode;   // 0: always ready, 1: toggle, 2: random
        logic [15:0] exp_id;
    } vec_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_miss = 0;
    int    exp_frames = 0;
    int    exp_stalls = 0;
    int    rdy_mode = 0;
    int    beat_no = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] csum_model(input logic [15:0] id);
        logic [31:0] s;
        logic [15:0] w [10];
        w = '{16'h4500, 16'h002D, id, 16'h4000, 16'h4011, 16'h0000,
              P_SRC_IP[31:16], P_SRC_IP[15:0], P_DST_IP[31:16], P_DST_IP[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s = s + {16'h0, w[i]};
        while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic push_frame(input logic [95:0] key, input logic [3:0] flag,
                              input logic [31:0] val, input logic [15:0] id);
        logic [7:0]  b [60];
        logic [15:0] cs;
        beat_t       e;
        int          k;
        cs = csum_model(id);
        for (int i = 0; i < 6; i++) begin
            b[i]     = P_DST_MAC[8*(5-i) +: 8];
            b[6+i]   = P_SRC_MAC[8*(5-i) +: 8];
        end
        b[12] = 8'h08; b[13] = 8'h00; b[14] = 8'h45; b[15] = 8'h00;
        b[16] = 8'h00; b[17] = 8'h2D; b[18] = id[15:8]; b[19] = id[7:0];
        b[20] = 8'h40; b[21] = 8'h00; b[22] = 8'h40; b[23] = 8'h11;
        b[24] = cs[15:8]; b[25] = cs[7:0];
        for (int i = 0; i < 4; i++) begin
            b[26+i] = P_SRC_IP[8*(3-i) +: 8];
            b[30+i] = P_DST_IP[8*(3-i) +: 8];
            b[55+i] = val[8*(3-i) +: 8];
        end
        b[34] = P_UDP_PORT[15:8]; b[35] = P_UDP_PORT[7:0];
        b[36] = P_UDP_PORT[15:8]; b[37] = P_UDP_PORT[7:0];
        b[38] = 8'h00; b[39] = 8'h19; b[40] = 8'h00; b[41] = 8'h00;
        b[42] = {4'h0, flag};
        for (int i = 0; i < 12; i++) b[43+i] = key[8*(11-i) +: 8];
        b[59] = 8'h00;
        for (int bt = 0; bt < 8; bt++) begin
            e.data = '0;
            for (int n = 0; n < 8; n++) begin
                k = 8*bt + n;
                if (k < 60) e.data[8*n +: 8] = b[k];
            end
            e.keep = (bt == 7) ? 8'h0F : 8'hFF;
            e.last = (bt == 7);
            exp_q.push_back(e);
        end
    endtask

    // tready generator
    initial forever begin
        @(posedge clk156);
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor / scoreboard
    initial begin
        logic        stalled;
        logic [63:0] h_data;
        logic [7:0]  h_keep;
        logic        h_last;
        beat_t       e;
        stalled = 1'b0;
        h_data = '0; h_keep = '0; h_last = 1'b0;
        forever begin
            @(negedge clk156);
            if (!eth_rst_n) begin
                stalled = 1'b0;
                beat_no = 0;
            end else begin
                if (stalled) begin
                    n_vec++;
                    if (!m_axis_tvalid || m_axis_tdata !== h_data ||
                        m_axis_tkeep !== h_keep || m_axis_tlast !== h_last) begin
                        n_miss++;
                        $display("FAIL hold_stable: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h l=%b",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                 h_data, h_keep, h_last);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    stalled = 1'b0;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL unexpected_beat: got d=%h l=%b expected no beat",
                                 m_axis_tdata, m_axis_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
                            m_axis_tlast !== e.last || m_axis_tuser !== 1'b0) begin
                            n_miss++;
                            $display("FAIL beat%0d: got d=%h k=%h l=%b u=%b expected d=%h k=%h l=%b u=0",
                                     beat_no, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                     m_axis_tuser, e.data, e.keep, e.last);
                        end else begin
                            $display("beat%0d ok d=%h k=%h l=%b", beat_no, m_axis_tdata,
                                     m_axis_tkeep, m_axis_tlast);
                        end
                        beat_no = e.last ? 0 : beat_no + 1;
                        if (e.last) exp_frames++;
                    end
                end else if (m_axis_tvalid) begin
                    stalled = 1'b1;
                    h_data = m_axis_tdata; h_keep = m_axis_tkeep; h_last = m_axis_tlast;
                    exp_stalls++;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Drives a request (req_valid left high) and checks the 2-cycle latency.
    task automatic send_req(input logic [95:0] key, input logic [3:0] flag,
                            input logic [31:0] val, input logic [15:0] id);
        bit got;
        got = 1'b0;
        req_key = key; req_flag = flag; req_val = val; req_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk156);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++; n_miss++;
            $display("FAIL req_accept: got req_ready=0 for 100 cycles expected 1");
            return;
        end
        push_frame(key, flag, val, id);
        $display("req key=%h flag=%h val=%h ip_id=%h accepted", key, flag, val, id);
        @(negedge clk156);
        chk("csum_cycle_tvalid", m_axis_tvalid, 0);
        chk("csum_cycle_req_ready", req_ready, 0);
        @(negedge clk156);
        chk("first_beat_tvalid", m_axis_tvalid, 1);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk156);
            #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++; n_miss++;
            $display("FAIL %s_drain: got %0d beats pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk156);
        #1;
        chk({name, "_idle_tvalid"}, m_axis_tvalid, 0);
    endtask

    task automatic chk_stats(input string name);
`ifdef KV_PKT_GEN_STATS_EN
        chk({name, "_tx_frames"}, tx_frames, exp_frames);
        chk({name, "_tx_stalls"}, tx_stalls, exp_stalls);
`else
        chk({name, "_tx_frames"}, tx_frames, 0);
        chk({name, "_tx_stalls"}, tx_stalls, 0);
`endif
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_tvalid"}, m_axis_tvalid, 0);
        chk({name, "_tlast"},  m_axis_tlast, 0);
        chk({name, "_tdata"},  m_axis_tdata, 0);
        chk({name, "_tkeep"},  m_axis_tkeep, 0);
        chk({name, "_tuser"},  m_axis_tuser, 0);
        chk({name, "_req_ready"}, req_ready, 0);
        chk({name, "_tx_frames"}, tx_frames, 0);
        chk({name, "_tx_stalls"}, tx_stalls, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    vec_t vecs [5];

    initial begin
        vecs[0] = '{96'h0102_0304_0506_0708_090A_0B0C, 4'h1, 32'hDEAD_BEEF, 0, 16'd0};
        vecs[1] = '{96'h0102_0304_0506_0708_090A_0B0C, 4'h1, 32'hDEAD_BEEF, 1, 16'd1};
        vecs[2] = '{{96{1'b1}},                        4'hF, 32'hFFFF_FFFF, 2, 16'd2};
        vecs[3] = '{96'h0,                             4'h0, 32'h0000_0000, 0, 16'd3};
        vecs[4] = '{96'hA5A5_5A5A_1234_5678_9ABC_DEF0, 4'hA, 32'h1234_5678, 1, 16'd4};

        // Reset state
        repeat (3) @(posedge clk156);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk156);
        eth_rst_n = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        chk("post_reset_req_ready", req_ready, 1);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            rdy_mode = vecs[i].rdy_mode;
            send_req(vecs[i].key, vecs[i].flag, vecs[i].val, vecs[i].exp_id);
            req_valid = 1'b0;
            drain($sformatf("vec%0d", i));
            chk_stats($sformatf("vec%0d", i));
        end

        // Three requests with req_valid held high throughout
        rdy_mode = 0;
        send_req(96'h1111_2222_3333_4444_5555_6666, 4'h3, 32'h0000_0001, 16'd5);
        send_req(96'h7777_8888_9999_AAAA_BBBB_CCCC, 4'h4, 32'h0000_0002, 16'd6);
        send_req(96'hDDDD_EEEE_FFFF_0000_1111_2222, 4'h5, 32'h0000_0003, 16'd7);
        req_valid = 1'b0;
        drain("b2b");
        chk_stats("b2b");

        // Reset asserted while beat 4 is on the bus
        send_req(96'h0BAD_F00D_0BAD_F00D_0BAD_F00D, 4'h6, 32'hCAFE_F00D, 16'd8);
        req_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk156);
            #1;
            if (exp_q.size() == 4) break;
        end
        chk("pre_abort_tvalid", m_axis_tvalid, 1);
        eth_rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_frames = 0;
        exp_stalls = 0;
        chk_reset_outputs("abort");
        @(negedge clk156);
        chk("abort_tvalid_next_edge", m_axis_tvalid, 0);
        eth_rst_n = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        send_req(96'hFEDC_BA98_7654_3210_0123_4567, 4'h7, 32'h8765_4321, 16'd0);
        req_valid = 1'b0;
        drain("post_abort");
        chk_stats("post_abort");

        // ip_id wrap 0xFFFF -> 0x0000
        @(posedge clk156);
        #1;
        force dut.r_ip_id = 16'hFFFF;
        @(posedge clk156);
        #1;
        release dut.r_ip_id;
        send_req(96'h0102_0304_0506_0708_090A_0B0C, 4'h1, 32'hDEAD_BEEF, 16'hFFFF);
        req_valid = 1'b0;
        drain("wrap_ffff");
        send_req(96'h0102_0304_0506_0708_090A_0B0C, 4'h1, 32'hDEAD_BEEF, 16'h0000);
        req_valid = 1'b0;
        drain("wrap_0000");
        chk_stats("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/kv_pkt_gen.md
KV_PKT_GEN -- requirements
Module: kv_pkt_gen

Interface
REQ-001 SHALL have parameter SRC_MAC, default 48'h00_11_22_33_44_55, source MAC.
REQ-002 SHALL have parameter DST_MAC, default 48'hFF_FF_FF_FF_FF_FF, destination MAC.
REQ-003 SHALL have parameter SRC_IP, default 32'hC0A8_0001, source IPv4 address.
REQ-004 SHALL have parameter DST_IP, default 32'hC0A8_0002, destination IPv4 address.
REQ-005 SHALL have parameter UDP_PORT, default 16'd8000, used as both the UDP source port and the UDP destination port.
REQ-006 SHALL have ports clk156 (in, 1, only clock) and eth_rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_key (in, 96), req_flag (in, 4), req_val (in, 32): the reply request from the KV lookup side.
REQ-008 SHALL have ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, 64), m_axis_tkeep (out, 8), m_axis_tlast (out, 1), m_axis_tuser (out, 1): the 10G MAC TX stream.
REQ-009 SHALL have ports tx_frames (out, 32) and tx_stalls (out, 32): statistics counters.

Function
REQ-010 SHALL implement the FSM states IDLE, CSUM and SEND.
REQ-011 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready it SHALL latch key/flag/val and go to CSUM.
REQ-012 CSUM SHALL last exactly 1 cycle, SHALL compute the IPv4 header checksum including the current ip_id, and SHALL then go to SEND with beat=0.
REQ-013 The first beat SHALL present tvalid 2 cycles after the accept cycle.
REQ-014 Each frame SHALL be 60 bytes in 8 beats; AXIS byte n of a beat SHALL be tdata[8n+7:8n]; all header fields SHALL be in network byte order.
REQ-015 The frame bytes SHALL be:
- 0-5 DST_MAC
- 6-11 SRC_MAC
- 12-13 0x0800
- 14 0x45
- 15 0x00
- 16-17 0x002D
- 18-19 ip_id
- 20-21 0x4000
- 22 0x40
- 23 0x11
- 24-25 checksum
- 26-29 SRC_IP
- 30-33 DST_IP
- 34-35 and 36-37 UDP_PORT
- 38-39 0x0019
- 40-41 0x0000
- 42 {4'h0,flag}
- 43-54 key, with byte 43 = req_key[95:88]
- 55-58 val, with byte 55 = req_val[31:24]
- 59 0x00 pad
REQ-016 tkeep SHALL be 8'hFF on beats 0-6 and 8'h0F on beat 7; tlast SHALL be 1 on beat 7 only; tuser SHALL always be 0.
REQ-017 Once tvalid is asserted, tdata/tkeep/tlast SHALL be held stable until tready; beat SHALL advance only on tvalid&&tready.
REQ-018 On the beat-7 handshake the FSM SHALL return to IDLE and ip_id SHALL increment; ip_id wraps 16'hFFFF->0.
REQ-019 The checksum SHALL be the ones-complement of the 16-bit ones-complement sum of the ten header words, with end-around carry folded twice.
REQ-020 Back-to-back requests SHALL be separated by at least 1 IDLE cycle; req_valid arriving during CSUM/SEND SHALL wait, not drop.

Reset
REQ-021 eth_rst_n low SHALL force IDLE, ip_id=0, req_ready=0 during reset then 1, tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0, tx_frames=0, tx_stalls=0.
REQ-022 Reset mid-frame SHALL abort the frame immediately with no tlast; the first post-reset frame SHALL be complete and use ip_id=0.

Configuration
REQ-023 With KV_PKT_GEN_STATS_EN defined, tx_frames SHALL increment on each tlast handshake and tx_stalls on each cycle tvalid&&!tready, both saturating at 32'hFFFFFFFF.
REQ-024 Without KV_PKT_GEN_STATS_EN, tx_frames and tx_stalls SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-025 Package kv_pkt_pkg SHALL hold the ETHERTYPE_IPV4, IP_PROTO_UDP, IP_TOTAL_LEN (45), UDP_LEN (25), FRAME_BEATS (8) and LAST_TKEEP constants and the FSM state typedef.
REQ-026 The checksum SHALL be a sub-module ip_csum16 (combinational ones-complement sum of ten 16-bit words), registered in CSUM.

Verification
REQ-027 Scenario: key=96'h0102..0C, flag=4'h1, val=32'hDEADBEEF, tready=1 -> 8 beats; beat5 byte2=0x01; beat7 tdata[31:0] bytes EF? No: bytes AD BE EF 00 in order; tkeep=0x0F; checksum=0x????-independent check vs reference model with ip_id=0.
REQ-028 Scenario: tready toggling 1/0 every cycle -> data stable while stalled; frame identical to the tready=1 case; tx_stalls=7 (STATS_EN).
REQ-029 Scenario: 3 requests held valid continuously -> three frames with ip_id 0,1,2; each req_ready pulse precedes its frame; tx_frames=3.
REQ-030 Scenario: eth_rst_n pulsed low at beat 4 -> tvalid=0 next edge, no tlast; next request yields a full frame with ip_id=0.
REQ-031 Scenario: ip_id preloaded via 65536 frames (or force) at 16'hFFFF -> next frame ip_id=0x0000 with a correct checksum.
